lvds_rx_word_packer_mm_writer: RTL and testbench
================================================

Name: lvds_rx_word_packer_mm_writer

Overview:
- Sits directly upstream of the 8192x32 single-port on-chip memory in the LVDS echo Qsys system.
- Accepts the LVDS receiver's byte stream and packs bytes little-endian into 32-bit words.
- Writes each word into the memory's Avalon-MM slave, treating the memory as a ring buffer. A downstream consumer drains it, and a frame-done pulse marks each completed frame.

Parameters:
- ADDR_W, 13, word address width; must match the memory's address port.
- DEPTH, 8192, ring size in words; equals 2**ADDR_W.
- CNT_W, 16, width of the per-frame word counter.

Ports:
- clk  in  1  system clock; all logic is single-clock.
- reset_n  in  1  reset, synchronous and active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid.
- rx_eop  in  1  qualifies rx_data as the last byte of a frame.
- rx_ready  out  1  byte accepted on a rising edge where rx_valid & rx_ready.
- avm_address  out  ADDR_W  word address.
- avm_byteenable  out  4  lane enables.
- avm_chipselect  out  1  Avalon chipselect.
- avm_write  out  1  Avalon write.
- avm_writedata  out  32  packed word.
- avm_waitrequest  in  1  slave stall; tie to 0 for on-chip memory.
- rd_ptr  in  ADDR_W  consumer's next word to read.
- wr_ptr  out  ADDR_W  next word address to be written.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- frame_words  out  CNT_W  words written in the current frame.
- overflow  out  1  sticky: rx_valid was seen while the ring was full.
- clear_overflow  in  1  clears overflow.

Behaviour:
- Reset (reset_n=0 at a rising edge) sets:
  - state=FILL, byte_cnt=0, lanes=0, eop_pend=0.
  - avm_* outputs all 0, wr_ptr=0, frame_done=0, frame_words=0, overflow=0.
  - rx_ready is 0 while reset_n=0.
- full = ((wr_ptr+1) mod DEPTH == rd_ptr). Usable capacity is DEPTH-1 words.
- States:
  - FILL: rx_ready = ~full.
    - Each accepted byte goes to avm_writedata[8*byte_cnt+7 : 8*byte_cnt] and sets avm_byteenable[byte_cnt]; byte_cnt then increments.
    - If the accepted byte has byte_cnt==3 or rx_eop=1, go to WRITE on the next edge and latch eop_pend=rx_eop.
  - WRITE: rx_ready=0; avm_chipselect=avm_write=1; avm_address=wr_ptr.
    - All avm_* outputs are held stable while avm_waitrequest=1.
    - The write completes at the edge where avm_waitrequest=0. At that edge:
      - wr_ptr increments mod DEPTH (DEPTH-1 wraps to 0).
      - frame_words increments, saturating at 2**CNT_W-1.
      - byte_cnt, lanes and writedata clear.
      - state returns to FILL.
    - If eop_pend=1 at completion: frame_done=1 for the following cycle, frame_words holds the final count that cycle, and frame_words resets to 0 the cycle after.
- Latency and throughput:
  - Byte 3 is accepted at edge N; the write is visible in cycle N+1 and completes at edge N+1 if avm_waitrequest=0.
  - rx_ready is high again in cycle N+2 if not full.
  - Peak throughput is 4 bytes per 5 cycles.
- Partial words: an eop on lane k writes byteenable = lanes 0..k only; unused lanes of writedata are 0.
- Full: no byte is accepted, so no data is lost. overflow sets on any cycle with state=FILL & full & rx_valid=1.
- clear_overflow clears overflow. If set and clear occur in the same cycle, set wins.
- rd_ptr is sampled combinationally.
- Any rd_ptr change that frees a slot raises rx_ready in the same cycle.
- Reset mid-operation: a partial word is discarded, no write is issued, and the next word goes to address 0, lane 0.
- rx_eop without rx_valid is ignored.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 with no eop, waitrequest=0 -> one write: address 0, writedata 0x44332211, byteenable 0xF; wr_ptr=1; frame_done stays 0.
- 6-byte frame 0xAA..0xFF with eop on 0xFF ->
  - write address 0: 0xDDCCBBAA, byteenable 0xF;
  - write address 1: 0x0000FFEE, byteenable 0x3;
  - frame_done pulses once with frame_words=2; frame_words is 0 the next cycle.
- waitrequest held high 3 cycles during a write -> avm signals stable for 4 cycles, rx_ready=0 throughout, exactly one write, wr_ptr advances once.
- Ring wrap: preload wr_ptr=8191 via stream, rd_ptr=100 -> write to address 8191, then wr_ptr=0, next write to address 0.
- Full: rd_ptr=wr_ptr+1 with rx_valid=1 ->
  - rx_ready=0 and overflow=1;
  - increment rd_ptr -> rx_ready=1 the same cycle;
  - clear_overflow pulse -> overflow=0.
- Reset mid-word: 2 bytes accepted, then reset_n=0 for one edge -> no avm_write; next 4 bytes land at address 0 with byteenable 0xF.

Source files
------------

// File: rtl/lvds_rx_word_packer_mm_writer.sv
// rtl/lvds_rx_word_packer_mm_writer.sv - packs LVDS rx bytes into 32-bit words and writes them into an Avalon-MM ring buffer
module lvds_rx_word_packer_mm_writer #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_eop,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_words,
    output logic              overflow,
    input  logic              clear_overflow
);

    localparam logic ST_FILL  = 1'b0;
    localparam logic ST_WRITE = 1'b1;

    logic              state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [3:0]        lanes_q, lanes_d;
    logic [31:0]       data_q, data_d;
    logic              eop_pend_q, eop_pend_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  frame_words_q, frame_words_d;
    logic              overflow_q, overflow_d;

    logic [ADDR_W-1:0] wr_ptr_inc;
    logic              full;
    logic              accept;
    logic [CNT_W-1:0]  frame_base;

    // Ring pointer arithmetic: one slot is kept empty so full and empty differ.
    always_comb begin
        if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
            wr_ptr_inc = '0;
        end else begin
            wr_ptr_inc = wr_ptr_q + 1'b1;
        end
        full     = (wr_ptr_inc == rd_ptr);
        rx_ready = reset_n & (state_q == ST_FILL) & ~full;
        accept   = rx_valid & rx_ready;
    end

    // Next-state logic for byte packing, the Avalon write handshake and frame accounting.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        lanes_d      = lanes_q;
        data_d       = data_q;
        eop_pend_d   = eop_pend_q;
        wr_ptr_d     = wr_ptr_q;
        frame_done_d = 1'b0;
        // The word count shown with a frame_done pulse is dropped one cycle later.
        frame_base    = frame_done_q ? '0 : frame_words_q;
        frame_words_d = frame_base;

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    data_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    lanes_d[byte_cnt_q]               = 1'b1;
                    byte_cnt_d                        = byte_cnt_q + 2'd1;
                    if ((byte_cnt_q == 2'd3) || rx_eop) begin
                        state_d    = ST_WRITE;
                        eop_pend_d = rx_eop;
                    end
                end
            end
            default: begin
                if (!avm_waitrequest) begin
                    wr_ptr_d = wr_ptr_inc;
                    if (!(&frame_base)) begin
                        frame_words_d = frame_base + 1'b1;
                    end
                    frame_done_d = eop_pend_q;
                    eop_pend_d   = 1'b0;
                    byte_cnt_d   = '0;
                    lanes_d      = '0;
                    data_d       = '0;
                    state_d      = ST_FILL;
                end
            end
        endcase

        // A new overflow event takes priority over a simultaneous clear.
        overflow_d = (overflow_q & ~clear_overflow)
                   | ((state_q == ST_FILL) & full & rx_valid);
    end

    // State registers with synchronous active-low reset; a partial word is discarded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_FILL;
            byte_cnt_q    <= '0;
            lanes_q       <= '0;
            data_q        <= '0;
            eop_pend_q    <= 1'b0;
            wr_ptr_q      <= '0;
            frame_done_q  <= 1'b0;
            frame_words_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            lanes_q       <= lanes_d;
            data_q        <= data_d;
            eop_pend_q    <= eop_pend_d;
            wr_ptr_q      <= wr_ptr_d;
            frame_done_q  <= frame_done_d;
            frame_words_q <= frame_words_d;
            overflow_q    <= overflow_d;
        end
    end

    // Avalon outputs come straight from registers, so they stay stable through waitrequest.
    always_comb begin
        avm_address    = wr_ptr_q;
        avm_byteenable = lanes_q;
        avm_writedata  = data_q;
        avm_chipselect = (state_q == ST_WRITE);
        avm_write      = (state_q == ST_WRITE);
        wr_ptr         = wr_ptr_q;
        frame_done     = frame_done_q;
        frame_words    = frame_words_q;
        overflow       = overflow_q;
    end

endmodule

// File: tb/tb_lvds_rx_word_packer_mm_writer.sv
// tb/tb_lvds_rx_word_packer_mm_writer.sv - self-checking bench for lvds_rx_word_packer_mm_writer
module tb_lvds_rx_word_packer_mm_writer;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 8192;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_eop;
    logic              rx_ready;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic              frame_done;
    logic [CNT_W-1:0]  frame_words;
    logic              overflow;
    logic              clear_overflow;

    lvds_rx_word_packer_mm_writer #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_eop         (rx_eop),
        .rx_ready       (rx_ready),
        .avm_address    (avm_address),
        .avm_byteenable (avm_byteenable),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .rd_ptr         (rd_ptr),
        .wr_ptr         (wr_ptr),
        .frame_done     (frame_done),
        .frame_words    (frame_words),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       data;
    } wr_t;

    int checks = 0;
    int errors = 0;
    bit rand_wait = 0;

    wr_t exp_wr[$];
    wr_t obs_wr[$];
    int  exp_fr[$];
    int  obs_fr[$];
    logic [CNT_W:0] obs_after[$];
    bit  after_pending = 0;

    int         m_addr;
    logic [7:0] m_bytes[$];
    int         m_words;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_addr  = 0;
        m_words = 0;
        m_bytes.delete();
    endfunction

    function automatic void model_push(input logic [7:0] b, input logic e);
        wr_t w;
        m_bytes.push_back(b);
        if (m_bytes.size() == 4 || e) begin
            w.data = '0;
            w.be   = '0;
            foreach (m_bytes[i]) begin
                w.data = w.data | (32'(m_bytes[i]) << (8 * i));
                w.be[i] = 1'b1;
            end
            w.addr = ADDR_W'(m_addr);
            exp_wr.push_back(w);
            m_addr = (m_addr + 1) % DEPTH;
            m_words++;
            if (e) begin
                exp_fr.push_back(m_words);
                m_words = 0;
            end
            m_bytes.delete();
        end
    endfunction

    // Observe completed writes and frame_done pulses away from the active edge.
    always @(negedge clk) begin
        if (after_pending) begin
            obs_after.push_back({frame_done, frame_words});
            after_pending = 0;
        end
        if (reset_n && avm_write && !avm_waitrequest)
            obs_wr.push_back({avm_address, avm_byteenable, avm_writedata});
        if (reset_n && frame_done) begin
            obs_fr.push_back(int'(frame_words));
            after_pending = 1;
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the byte.
    task automatic send(input logic [7:0] b, input logic e);
        int n;
        bit ok;
        rx_data  = b;
        rx_valid = 1'b1;
        rx_eop   = e;
        n  = 0;
        ok = 0;
        while (n < 200) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            if (rand_wait) avm_waitrequest = ($urandom_range(0, 2) == 0);
            n++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
            model_push(b, e);
        end else begin
            chk("accept_timeout", 64'd0, 64'd1);
        end
        rx_valid = 1'b0;
        rx_eop   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], 1'b0);
    endtask

    task automatic drain_and_check(input string tag);
        wr_t e, o;
        logic [CNT_W:0] a;
        avm_waitrequest = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk({tag, "_nwrites"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            chk({tag, "_write"}, 64'(o), 64'(e));
        end
        chk({tag, "_nframes"}, 64'(obs_fr.size()), 64'(exp_fr.size()));
        while (exp_fr.size() > 0 && obs_fr.size() > 0)
            chk({tag, "_frame_words"}, 64'(obs_fr.pop_front()), 64'(exp_fr.pop_front()));
        while (obs_after.size() > 0) begin
            a = obs_after.pop_front();
            chk({tag, "_after_frame"}, 64'(a), 64'd0);
        end
        exp_wr.delete();
        obs_wr.delete();
        exp_fr.delete();
        obs_fr.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        chk("ready_in_reset", 64'(rx_ready), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] first;
        int len;

        reset_n = 1'b0;
        rx_data = '0;
        rx_valid = 1'b0;
        rx_eop = 1'b0;
        avm_waitrequest = 1'b0;
        rd_ptr = '0;
        clear_overflow = 1'b0;
        model_reset();

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(rx_ready), 64'd0);
        chk("rst_write", 64'({avm_chipselect, avm_write}), 64'd0);
        chk("rst_addr", 64'(avm_address), 64'd0);
        chk("rst_be_data", 64'({avm_byteenable, avm_writedata}), 64'd0);
        chk("rst_ptr", 64'(wr_ptr), 64'd0);
        chk("rst_frame", 64'({frame_done, frame_words, overflow}), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1;

        // One full word, with a stray eop (no valid) in the middle that must be ignored
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        rx_eop = 1'b1;
        @(posedge clk);
        #1;
        rx_eop = 1'b0;
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        drain_and_check("A");
        chk("A_wr_ptr", 64'(wr_ptr), 64'(m_addr));

        // Six-byte frame ending in a partial word
        do_reset();
        for (int i = 0; i < 6; i++) send(8'hAA + 8'(17 * i), (i == 5));
        drain_and_check("B");

        // Write stalled by waitrequest for three cycles
        avm_waitrequest = 1'b1;
        send_word(32'h0D0C0B0A);
        first = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("C_write", 64'({avm_chipselect, avm_write}), 64'd3);
            chk("C_ready", 64'(rx_ready), 64'd0);
            if (i == 0) first = 64'({avm_address, avm_byteenable, avm_writedata});
            else chk("C_stable", 64'({avm_address, avm_byteenable, avm_writedata}), first);
            @(posedge clk);
            #1;
            if (i == 2) avm_waitrequest = 1'b0;
        end
        chk("C_wr_ptr", 64'(wr_ptr), 64'(m_addr));
        drain_and_check("C");

        // Random frames under random waitrequest stalls
        rand_wait = 1;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, 11);
            for (int i = 0; i < len; i++) send(8'($urandom), (i == len - 1));
        end
        rand_wait = 0;
        drain_and_check("D");

        // Ring wrap: fill up to the last slot while the consumer keeps pace
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) begin
            rd_ptr = ADDR_W'((m_addr + DEPTH - 1) % DEPTH);
            send_word($urandom);
        end
        drain_and_check("E_pre");
        chk("E_ptr_last", 64'(wr_ptr), 64'(DEPTH - 1));
        rd_ptr = ADDR_W'(100);
        send_word(32'hCAFEF00D);
        drain_and_check("E_last");
        chk("E_ptr_wrap", 64'(wr_ptr), 64'd0);
        send_word(32'h12345678);
        drain_and_check("E_zero");
        chk("E_no_ovf", 64'(overflow), 64'd0);

        // Full ring: nothing accepted, sticky overflow, set beats clear
        rd_ptr = ADDR_W'((m_addr + 1) % DEPTH);
        rx_data = 8'h5A;
        rx_valid = 1'b1;
        @(negedge clk);
        chk("F_ready_full", 64'(rx_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("F_ovf_set", 64'(overflow), 64'd1);
        clear_overflow = 1'b1;
        @(posedge clk);
        #1;
        clear_overflow = 1'b0;
        chk("F_set_wins", 64'(overflow), 64'd1);
        rx_valid = 1'b0;
        rd_ptr = ADDR_W'((m_addr + 2) % DEPTH);
        @(negedge clk);
        chk("F_ready_freed", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1;
        clear_overflow = 1'b1;
        @(posedge clk);
        #1;
        clear_overflow = 1'b0;
        chk("F_ovf_clear", 64'(overflow), 64'd0);
        drain_and_check("F");

        // Reset in the middle of a word discards it
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        do_reset();
        rd_ptr = ADDR_W'(DEPTH / 2);
        send_word(32'h89ABCDEF);
        drain_and_check("G");
        chk("G_wr_ptr", 64'(wr_ptr), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
